// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED bank controller.
//   mode_e     : display source selected by the mode FSM (also the encoding on
//                the mode output port).
//   SHIFT_SEED : pattern loaded when the running light starts.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic [6:0] SHIFT_SEED = 7'b0000001;

endpackage

// File: rtl/led_bank_ctrl_sw_debounce.sv
// sw_debounce: one asynchronous input bit -> 2-flop synchroniser -> debouncer.
// The debounced value follows the synchronised value only after it has
// disagreed for DB_CYC consecutive cycles; shorter glitches are dropped.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   din  in  raw input, asynchronous to clk
//   dout out debounced value (registered)
module sw_debounce #(
  parameter int DB_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYC);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: drives the LED bank from one of four sources chosen by a
// mode button: switch mirror, running light, blink, binary counter.
// Optional feature macro: LED_PWM_EN (registered PWM dimming of the LEDs).
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   sw       in   raw switches [SW_W-1:0], asynchronous
//   btn_mode in   raw mode button, asynchronous, active-high
//   led      out  LED drive [SW_W-1:0], registered
//   mode     out  current mode (0 MIRROR, 1 SHIFT, 2 BLINK, 3 COUNT)
//
// Mode FSM:
//   state       | meaning
//   MODE_MIRROR | led follows debounced switches
//   MODE_SHIFT  | single lit LED rotates left once per tick
//   MODE_BLINK  | switches shown / blanked on alternate ticks
//   MODE_COUNT  | binary counter advancing once per tick
module led_bank_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int SW_W     = 7,
  parameter int DB_CYC   = 1000,
  parameter int TICK_DIV = 1000000,
  parameter int PWM_DUTY = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  input  logic            btn_mode,
  output logic [SW_W-1:0] led,
  output logic [1:0]      mode
);

  localparam int TW = $clog2(TICK_DIV);

  logic [SW_W:0]   raw_in;
  logic [SW_W:0]   db_out;
  logic [SW_W-1:0] sw_db;
  logic            btn_db;

  assign raw_in = {btn_mode, sw};

  for (genvar i = 0; i <= SW_W; i++) begin : g_db
    sw_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (raw_in[i]),
      .dout (db_out[i])
    );
  end

  assign sw_db  = db_out[SW_W-1:0];
  assign btn_db = db_out[SW_W];

  mode_e           mode_q, mode_d;
  logic            btn_prev_q, btn_prev_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SW_W-1:0] shift_q, shift_d;
  logic            blink_on_q, blink_on_d;
  logic [SW_W-1:0] count_q, count_d;
  logic [SW_W-1:0] led_q, led_d;
  logic            press;
  logic            tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_MIRROR;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    btn_prev_d = btn_db;
    press      = btn_db & ~btn_prev_q;
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    mode_d     = mode_q;
    shift_d    = shift_q;
    blink_on_d = blink_on_q;
    count_d    = count_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // A press outranks a coincident tick: entry values load and the tick
    // is dropped, so each mode starts from a clean tick period.
    if (press) begin
      tick_cnt_d = '0;
      unique case (mode_q)
        MODE_MIRROR: begin
          mode_d  = MODE_SHIFT;
          shift_d = SW_W'(SHIFT_SEED);
        end
        MODE_SHIFT: begin
          mode_d     = MODE_BLINK;
          blink_on_d = 1'b1;
        end
        MODE_BLINK: begin
          mode_d  = MODE_COUNT;
          count_d = '0;
        end
        MODE_COUNT: mode_d = MODE_MIRROR;
      endcase
    end else if (tick) begin
      unique case (mode_q)
        MODE_MIRROR: ;
        MODE_SHIFT:  shift_d    = {shift_q[SW_W-2:0], shift_q[SW_W-1]};
        MODE_BLINK:  blink_on_d = ~blink_on_q;
        MODE_COUNT:  count_d    = count_q + 1'b1;
      endcase
    end

    // Output follows the next-state values so led and mode change together.
    unique case (mode_d)
      MODE_MIRROR: led_d = sw_db;
      MODE_SHIFT:  led_d = shift_d;
      MODE_BLINK:  led_d = blink_on_d ? sw_db : '0;
      MODE_COUNT:  led_d = count_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= 1'b0;
      tick_cnt_q <= '0;
      shift_q    <= '0;
      blink_on_q <= 1'b0;
      count_q    <= '0;
      led_q      <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      tick_cnt_q <= tick_cnt_d;
      shift_q    <= shift_d;
      blink_on_q <= blink_on_d;
      count_q    <= count_d;
      led_q      <= led_d;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [SW_W-1:0] led_pwm_q, led_pwm_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    led_pwm_d = ({1'b0, pwm_cnt_q} < 9'(PWM_DUTY)) ? led_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      led_pwm_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_pwm_q <= led_pwm_d;
    end
  end

  assign led = led_pwm_q;
`else
  assign led = led_q;
`endif

  assign mode = mode_q;

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Self-checking bench for led_bank_ctrl with DB_CYC=4, TICK_DIV=8.
module tb_led_bank_ctrl;

  localparam int TDIV = 8;

  logic       clk;
  logic       rst;
  logic [6:0] sw;
  logic       btn_mode;
  logic [6:0] led;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  led_bank_ctrl #(
    .SW_W     (7),
    .DB_CYC   (4),
    .TICK_DIV (TDIV),
    .PWM_DUTY (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .btn_mode (btn_mode),
    .led      (led),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: what the LED bank shows c cycles after entering mode m with
  // steady switches swv.
  function automatic logic [6:0] exp_led(int m, int c, logic [6:0] swv);
    int t;
    t = c / TDIV;
    case (m)
      0:       return swv;
      1:       return 7'(1 << (t % 7));
      2:       return ((t % 2) == 0) ? swv : 7'h00;
      default: return 7'(t % 128);
    endcase
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises the button until the mode changes (bounded), then releases it.
  // lat = cycles from raising to the mode change, -1 on timeout.
  task automatic press_btn(output int lat);
    logic [1:0] m0;
    lat = -1;
    m0 = mode;
    btn_mode = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (mode !== m0) begin
        lat = i;
        break;
      end
    end
    btn_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 7'h7F;
    btn_mode = 1'b0;
    #2;
    checks++;
    if (led !== 7'h00) begin errors++; $display("FAIL reset_led actual=%h required=%h", led, 7'h00); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode actual=%0d required=%0d", mode, 0); end
    step(3);
    rst = 1'b0;
    step(6);
    checks++;
    if (led !== 7'h00) begin errors++; $display("FAIL reset_release_early actual=%h required=%h", led, 7'h00); end
    step(1);
    checks++;
    if (led !== 7'h7F) begin errors++; $display("FAIL reset_release_led actual=%h required=%h", led, 7'h7F); end
  endtask

  task automatic test_mirror();
    logic [6:0] prev;
    logic [6:0] v;
    int gl;
    int bit_i;
    sw = 7'h00;
    step(10);
    sw = 7'h55;
    step(6);
    checks++;
    if (led !== 7'h00) begin errors++; $display("FAIL mirror_latency_early actual=%h required=%h", led, 7'h00); end
    step(1);
    checks++;
    if (led !== 7'h55) begin errors++; $display("FAIL mirror_latency actual=%h required=%h", led, 7'h55); end
    sw = 7'h55 ^ 7'h08;
    step(2);
    sw = 7'h55;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (led !== 7'h55) begin errors++; $display("FAIL mirror_glitch cyc=%0d actual=%h required=%h", i, led, 7'h55); end
    end
    prev = 7'h55;
    for (int k = 0; k < 6; k++) begin
      v = 7'($urandom_range(0, 127));
      sw = v;
      step(6);
      checks++;
      if (led !== prev) begin errors++; $display("FAIL mirror_rand_early it=%0d actual=%h required=%h", k, led, prev); end
      step(1);
      checks++;
      if (led !== v) begin errors++; $display("FAIL mirror_rand it=%0d actual=%h required=%h", k, led, v); end
      step($urandom_range(0, 3));
      gl = $urandom_range(1, 3);
      bit_i = $urandom_range(0, 6);
      sw = v ^ 7'(1 << bit_i);
      step(gl);
      sw = v;
      for (int i = 0; i < 10; i++) begin
        step(1);
        checks++;
        if (led !== v) begin errors++; $display("FAIL mirror_rand_glitch it=%0d len=%0d actual=%h required=%h", k, gl, led, v); end
      end
      prev = v;
    end
  endtask

  task automatic test_mode_cycle();
    int entry;
    int changes;
    int c;
    logic [1:0] pm;
    logic [6:0] e;
    sw = 7'h2A;
    step(10);
    entry = -1;
    changes = 0;
    pm = mode;
    btn_mode = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (mode !== pm) begin
        changes++;
        pm = mode;
        if (entry < 0) entry = i;
      end
      if (entry >= 0) begin
        e = exp_led(1, i - entry, 7'h2A);
        checks++;
        if (led !== e) begin errors++; $display("FAIL shift_pattern c=%0d actual=%h required=%h", i - entry, led, e); end
      end
    end
    checks++;
    if (entry != 7) begin errors++; $display("FAIL press_latency actual=%0d required=%0d", entry, 7); end
    checks++;
    if (changes != 1) begin errors++; $display("FAIL held_button_presses actual=%0d required=%0d", changes, 1); end
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL mode_shift actual=%0d required=%0d", mode, 1); end
    btn_mode = 1'b0;
    c = 100 - entry;
    for (int i = 0; i < 10; i++) begin
      step(1);
      c++;
      e = exp_led(1, c, 7'h2A);
      checks++;
      if (led !== e || mode !== 2'd1) begin
        errors++;
        $display("FAIL shift_after_release c=%0d actual=%h/%0d required=%h/%0d", c, led, mode, e, 1);
      end
    end
  endtask

  task automatic test_blink();
    int lat;
    logic [6:0] e;
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd2) begin errors++; $display("FAIL blink_entry lat=%0d mode=%0d required lat=7 mode=2", lat, mode); end
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) step(1);
      e = exp_led(2, c, 7'h2A);
      checks++;
      if (led !== e) begin errors++; $display("FAIL blink c=%0d actual=%h required=%h", c, led, e); end
    end
  endtask

  task automatic test_count();
    int lat;
    logic [6:0] e;
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd3) begin errors++; $display("FAIL count_entry lat=%0d mode=%0d required lat=7 mode=3", lat, mode); end
    for (int c = 0; c <= 128 * TDIV; c++) begin
      if (c > 0) step(1);
      e = exp_led(3, c, 7'h2A);
      checks++;
      if (led !== e) begin errors++; $display("FAIL count c=%0d actual=%h required=%h", c, led, e); end
    end
    // The counter just advanced; a press raised one cycle later lands on
    // the edge of the next tick.
    step(1);
    press_btn(lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL count_tick_press_latency actual=%0d required=%0d", lat, 7); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL count_tick_press_mode actual=%0d required=%0d", mode, 0); end
    checks++;
    if (led !== 7'h2A) begin errors++; $display("FAIL count_tick_press_led actual=%h required=%h", led, 7'h2A); end
  endtask

  task automatic test_press_on_tick();
    int lat;
    logic [6:0] r;
    logic [6:0] e;
    r = 7'($urandom_range(1, 127));
    sw = r;
    step(12);
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd1) begin errors++; $display("FAIL pot_shift_entry lat=%0d mode=%0d required lat=7 mode=1", lat, mode); end
    for (int c = 1; c <= 2 * TDIV; c++) begin
      step(1);
      e = exp_led(1, c, r);
      checks++;
      if (led !== e) begin errors++; $display("FAIL pot_shift c=%0d actual=%h required=%h", c, led, e); end
    end
    step(1);
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd2) begin errors++; $display("FAIL pot_blink_entry lat=%0d mode=%0d required lat=7 mode=2", lat, mode); end
    for (int c = 0; c <= 2 * TDIV; c++) begin
      if (c > 0) step(1);
      e = exp_led(2, c, r);
      checks++;
      if (led !== e) begin errors++; $display("FAIL pot_blink c=%0d actual=%h required=%h", c, led, e); end
    end
    step(4);
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd3) begin errors++; $display("FAIL pot_count_entry lat=%0d mode=%0d required lat=7 mode=3", lat, mode); end
    step(12);
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd0 || led !== r) begin
      errors++;
      $display("FAIL pot_mirror_entry lat=%0d mode=%0d led=%h required lat=7 mode=0 led=%h", lat, mode, led, r);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic [6:0] e;
    step(12);
    press_btn(lat);
    checks++;
    if (lat != 7 || mode !== 2'd1) begin errors++; $display("FAIL rms_entry lat=%0d mode=%0d required lat=7 mode=1", lat, mode); end
    for (int c = 1; c <= 26; c++) begin
      step(1);
      e = exp_led(1, c, sw);
      checks++;
      if (led !== e) begin errors++; $display("FAIL rms_shift c=%0d actual=%h required=%h", c, led, e); end
    end
    checks++;
    if (led !== 7'h08) begin errors++; $display("FAIL rms_before_reset actual=%h required=%h", led, 7'h08); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 7'h00) begin errors++; $display("FAIL rms_async_led actual=%h required=%h", led, 7'h00); end
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL rms_async_mode actual=%0d required=%0d", mode, 0); end
    step(2);
    rst = 1'b0;
    step(3);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL rms_after_release_mode actual=%0d required=%0d", mode, 0); end
  endtask

  initial begin
    test_reset();
    test_mirror();
    test_mode_cycle();
    test_blink();
    test_count();
    test_press_on_tick();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
